addsub_operand_capture: RTL and testbench
=========================================

// Module: addsub_operand_capture
// PURPOSE
//  Front-end stage feeding the 4-bit add/sub display wrapper. Synchronises and debounces
//  the raw board switches (A, B, Sub) and a LOAD push-button, then latches a stable operand
//  set on each debounced LOAD press. Downstream sees operands change only on a clean press.
//  Also drives a "dirty" LED when the switches differ from the latched operands.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  stable clk_main cycles required before an input change is accepted (>=2)
//  SYNC_STAGES      2          flip-flop stages in the input synchroniser (>=2)
// PORTS
//  clk_main      in   1  system clock; sole clock domain
//  reset_n       in   1  asynchronous, active-low reset
//  sw_A          in   4  raw switch operand A (asynchronous)
//  sw_B          in   4  raw switch operand B (asynchronous)
//  sw_Sub        in   1  raw switch: 1 = subtract, 0 = add (asynchronous)
//  btn_load      in   1  raw LOAD push-button, active-high (asynchronous)
//  A             out  4  latched operand A to the add/sub wrapper
//  B             out  4  latched operand B
//  Sub           out  1  latched operation select
//  load_strobe   out  1  one-cycle pulse in the cycle A/B/Sub update
//  LED_dirty     out  1  1 while debounced switches != latched {A,B,Sub}
// BEHAVIOUR
//  - Reset (reset_n=0, async): A=0, B=0, Sub=0, load_strobe=0, LED_dirty=0; sync chains,
//    debounce counters and candidates cleared; FSM -> IDLE. Reset mid-press or mid-debounce
//    aborts it; after release, the button must be seen released before a press is accepted.
//  - Sync: all 10 raw inputs pass through SYNC_STAGES flops before any other logic.
//  - Debounce (switch bus, 9 bits, as one word): candidate register + counter. If the synced
//    word != candidate: candidate <= synced word, counter <= 0. Else if counter ==
//    DEBOUNCE_CYCLES-1: stable word <= candidate (counter saturates). Else counter+1.
//    Counter width $clog2(DEBOUNCE_CYCLES). Button debounced identically, separate counter.
//  - Total latency raw change -> stable: SYNC_STAGES + DEBOUNCE_CYCLES cycles (+/-1 cycle).
//  - FSM (button, states IDLE, LOAD, WAIT_REL):
//    IDLE: btn_stable=1 -> LOAD. LOAD (exactly 1 cycle): {A,B,Sub} <= stable switch word,
//    load_strobe=1 -> WAIT_REL. WAIT_REL: btn_stable=0 -> IDLE; holding the button gives one
//    load only. load_strobe is 0 in every state except LOAD.
//  - Switch bouncing when LOAD fires: latches the last *stable* word, never the raw/candidate.
//  - Stable word changing in the same cycle as LOAD: LOAD captures the pre-update value;
//    LED_dirty rises next cycle.
//  - LED_dirty registered: (stable word != {A,B,Sub}), 1-cycle lag; clears the cycle after LOAD.
//  - No arithmetic besides counters; outputs are plain registers, no combinational path from inputs.
// CONFIGURATION
//  AUTO_LOAD_EN defined: button/FSM bypassed; whenever the stable word changes,
//    {A,B,Sub} update next cycle with a one-cycle load_strobe; LED_dirty tied 0; btn_load ignored.
//  AUTO_LOAD_EN undefined: button-gated behaviour above (default build).
// STRUCTURE
//  - Shared package addsub_io_pkg: OPERAND_W=4, SW_BUS_W=9 (A,B,Sub packing {A,B,Sub}),
//    capture-FSM state typedef {IDLE, LOAD, WAIT_REL}.
//  - Sub-module debounce_filter #(WIDTH, DEBOUNCE_CYCLES, SYNC_STAGES): sync + debounce of a
//    WIDTH-bit bus; instantiated twice (WIDTH=9 switches, WIDTH=1 button).
//  - Top holds FSM, operand registers, strobe and dirty logic.
// TESTING  (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//  1 Reset: hold reset_n=0 with switches=A5/B3/Sub1 -> A=0,B=0,Sub=0,load_strobe=0,LED_dirty=0.
//  2 Clean load: sw_A=5,sw_B=3,sw_Sub=1 stable, press btn 20 cycles -> exactly one strobe;
//    A=5,B=3,Sub=1; LED_dirty 1 before press, 0 after.
//  3 Bounce: toggle btn_load every 2 cycles for 12 cycles then hold 1 -> one strobe only,
//    arriving ~SYNC_STAGES+DEBOUNCE_CYCLES after final edge.
//  4 Switch bounce: sw_A toggles 7<->8 each cycle, press LOAD -> A holds previous stable value
//    (not 7/8) until sw_A settles and a new press occurs.
//  5 Hold: btn held 100 cycles, switches changed to A=9 mid-hold -> no second strobe;
//    LED_dirty=1; release+press -> A=9.
//  6 Reset mid-press: reset_n pulsed low in WAIT_REL with btn still high -> outputs 0; no
//    strobe until btn released and pressed again. AUTO_LOAD_EN build: change sw_B to 6 ->
//    one strobe, B=6, no button.

Source files
------------

// File: rtl/addsub_io_pkg.sv
// Shared definitions for the add/sub operand front-end: operand widths,
// switch-bus packing and the capture FSM state type.
package addsub_io_pkg;

  localparam int unsigned OPERAND_W = 4;
  localparam int unsigned SW_BUS_W  = 2 * OPERAND_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_REL
  } capture_state_t;

  // Switch bus packing is {A, B, Sub}, MSB first.
  function automatic logic [SW_BUS_W-1:0] pack_sw(
    input logic [OPERAND_W-1:0] a,
    input logic [OPERAND_W-1:0] b,
    input logic                 sub
  );
    return {a, b, sub};
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Synchroniser plus word-wide debouncer for a WIDTH-bit asynchronous bus.
// The whole bus is treated as one word: any bit changing restarts the count.
// o_valid rises the first time a word is accepted after reset, letting the
// consumer tell a debounced 0 apart from the reset value.
module debounce_filter #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable,
  output logic             o_valid
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_synced;
  logic [WIDTH-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_stable;
  logic             r_valid;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;
  assign o_valid  = r_valid;

  // Multi-stage synchroniser for the raw asynchronous inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Candidate/counter debounce; counter saturates once the word is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
      r_valid  <= 1'b0;
    end else if (w_synced != r_cand) begin
      r_cand <= w_synced;
      r_cnt  <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_stable <= r_cand;
      r_valid  <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/addsub_operand_capture.sv
// Operand capture front-end for the 4-bit add/sub display wrapper.
// Debounces switches and the LOAD button, latches {A,B,Sub} on a clean press
// and flags (LED_dirty) when the switches differ from the latched operands.
// Build option: define AUTO_LOAD_EN to bypass the button and reload the
// operands whenever the debounced switch word changes.
module addsub_operand_capture
  import addsub_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                 clk_main,
  input  logic                 reset_n,
  input  logic [OPERAND_W-1:0] sw_A,
  input  logic [OPERAND_W-1:0] sw_B,
  input  logic                 sw_Sub,
  input  logic                 btn_load,
  output logic [OPERAND_W-1:0] A,
  output logic [OPERAND_W-1:0] B,
  output logic                 Sub,
  output logic                 load_strobe,
  output logic                 LED_dirty
);

  logic [SW_BUS_W-1:0]  w_sw_raw;
  logic [SW_BUS_W-1:0]  w_sw_stable;
  logic [SW_BUS_W-1:0]  w_captured;
  logic                 w_unused_sw_valid;
  logic [OPERAND_W-1:0] r_A;
  logic [OPERAND_W-1:0] r_B;
  logic                 r_Sub;
  logic                 r_strobe;
  logic                 r_dirty;

  assign w_sw_raw    = pack_sw(sw_A, sw_B, sw_Sub);
  assign w_captured  = pack_sw(r_A, r_B, r_Sub);
  assign A           = r_A;
  assign B           = r_B;
  assign Sub         = r_Sub;
  assign load_strobe = r_strobe;
  assign LED_dirty   = r_dirty;

  debounce_filter #(
    .WIDTH          (SW_BUS_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_sw_db (
    .i_clk   (clk_main),
    .i_rst_n (reset_n),
    .i_raw   (w_sw_raw),
    .o_stable(w_sw_stable),
    .o_valid (w_unused_sw_valid)
  );

`ifdef AUTO_LOAD_EN

  logic w_unused_btn;
  assign w_unused_btn = btn_load;

  // Reload operands the cycle after the debounced switch word moves away from them.
  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      r_A      <= '0;
      r_B      <= '0;
      r_Sub    <= 1'b0;
      r_strobe <= 1'b0;
    end else if (w_sw_stable != w_captured) begin
      {r_A, r_B, r_Sub} <= w_sw_stable;
      r_strobe          <= 1'b1;
    end else begin
      r_strobe <= 1'b0;
    end
  end

  // Operands always track the switches here, so nothing is ever dirty.
  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) r_dirty <= 1'b0;
    else          r_dirty <= 1'b0;
  end

`else

  capture_state_t r_state;
  logic [0:0]     w_btn_stable;
  logic           w_btn_valid;
  logic           r_armed;

  debounce_filter #(
    .WIDTH          (1),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_btn_db (
    .i_clk   (clk_main),
    .i_rst_n (reset_n),
    .i_raw   (btn_load),
    .o_stable(w_btn_stable),
    .o_valid (w_btn_valid)
  );

  // Arm only after a genuinely debounced release, so a press held through reset is ignored.
  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n)                         r_armed <= 1'b0;
    else if (w_btn_valid && !w_btn_stable[0]) r_armed <= 1'b1;
  end

  // Capture FSM. Operands and strobe are registered on the transition into
  // LOAD, so they become visible together during the LOAD cycle.
  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_A      <= '0;
      r_B      <= '0;
      r_Sub    <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_strobe <= 1'b0;
          if (w_btn_stable[0] && r_armed) begin
            {r_A, r_B, r_Sub} <= w_sw_stable;
            r_strobe          <= 1'b1;
            r_state           <= LOAD;
          end
        end
        LOAD: begin
          r_strobe <= 1'b0;
          r_state  <= WAIT_REL;
        end
        WAIT_REL: begin
          r_strobe <= 1'b0;
          if (!w_btn_stable[0]) r_state <= IDLE;
        end
        default: begin
          r_strobe <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  // Dirty flag: debounced switches differ from the latched operands (one-cycle lag).
  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) r_dirty <= 1'b0;
    else          r_dirty <= (w_sw_stable != w_captured);
  end

`endif

endmodule

// File: tb/tb_addsub_operand_capture.sv
// Self-checking bench for addsub_operand_capture (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
module tb_addsub_operand_capture;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SYNC = 2;

  logic       clk_main = 1'b0;
  logic       reset_n  = 1'b0;
  logic [3:0] sw_A     = '0;
  logic [3:0] sw_B     = '0;
  logic       sw_Sub   = 1'b0;
  logic       btn_load = 1'b0;
  logic [3:0] A;
  logic [3:0] B;
  logic       Sub;
  logic       load_strobe;
  logic       LED_dirty;

  int unsigned n_tests  = 0;
  int unsigned n_fail   = 0;
  int unsigned n_strobe = 0;

  // Reference model state: operands the design should currently hold.
  logic [3:0] exp_A   = '0;
  logic [3:0] exp_B   = '0;
  logic       exp_Sub = 1'b0;

  addsub_operand_capture #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk_main   (clk_main),
    .reset_n    (reset_n),
    .sw_A       (sw_A),
    .sw_B       (sw_B),
    .sw_Sub     (sw_Sub),
    .btn_load   (btn_load),
    .A          (A),
    .B          (B),
    .Sub        (Sub),
    .load_strobe(load_strobe),
    .LED_dirty  (LED_dirty)
  );

  always #5 clk_main = ~clk_main;

  always @(posedge clk_main) begin
    #1;
    if (load_strobe) n_strobe++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_main);
  endtask

  task automatic press(input int hold, input int rel);
    btn_load = 1'b1;
    step(hold);
    btn_load = 1'b0;
    step(rel);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    sw_A = 4'd5; sw_B = 4'd3; sw_Sub = 1'b1; btn_load = 1'b0;
    step(5);
    n_tests++; if (A !== 4'd0) begin n_fail++; $display("FAIL reset_A: got %0d expected 0", A); end
    n_tests++; if (B !== 4'd0) begin n_fail++; $display("FAIL reset_B: got %0d expected 0", B); end
    n_tests++; if (Sub !== 1'b0) begin n_fail++; $display("FAIL reset_Sub: got %0b expected 0", Sub); end
    n_tests++; if (load_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %0b expected 0", load_strobe); end
    n_tests++; if (LED_dirty !== 1'b0) begin n_fail++; $display("FAIL reset_dirty: got %0b expected 0", LED_dirty); end
    reset_n = 1'b1;
    step(15);
  endtask

`ifdef AUTO_LOAD_EN

  task automatic test_auto_load;
    int unsigned s0;
    // The switches set during reset were loaded automatically after release.
    n_tests++; if (A !== 4'd5) begin n_fail++; $display("FAIL auto_initial_A: got %0d expected 5", A); end
    s0 = n_strobe;
    sw_B = 4'd6;
    btn_load = 1'b1;
    step(20);
    btn_load = 1'b0;
    step(5);
    n_tests++; if (n_strobe - s0 !== 1) begin n_fail++; $display("FAIL auto_strobes: got %0d expected 1", n_strobe - s0); end
    n_tests++; if (B !== 4'd6) begin n_fail++; $display("FAIL auto_B: got %0d expected 6", B); end
    n_tests++; if (A !== 4'd5) begin n_fail++; $display("FAIL auto_A: got %0d expected 5", A); end
    n_tests++; if (LED_dirty !== 1'b0) begin n_fail++; $display("FAIL auto_dirty: got %0b expected 0", LED_dirty); end
  endtask

`else

  task automatic test_clean_load;
    int unsigned s0;
    n_tests++; if (LED_dirty !== 1'b1) begin n_fail++; $display("FAIL clean_dirty_before: got %0b expected 1", LED_dirty); end
    s0 = n_strobe;
    press(20, 15);
    exp_A = 4'd5; exp_B = 4'd3; exp_Sub = 1'b1;
    n_tests++; if (n_strobe - s0 !== 1) begin n_fail++; $display("FAIL clean_strobes: got %0d expected 1", n_strobe - s0); end
    n_tests++; if (A !== exp_A) begin n_fail++; $display("FAIL clean_A: got %0d expected %0d", A, exp_A); end
    n_tests++; if (B !== exp_B) begin n_fail++; $display("FAIL clean_B: got %0d expected %0d", B, exp_B); end
    n_tests++; if (Sub !== exp_Sub) begin n_fail++; $display("FAIL clean_Sub: got %0b expected %0b", Sub, exp_Sub); end
    n_tests++; if (LED_dirty !== 1'b0) begin n_fail++; $display("FAIL clean_dirty_after: got %0b expected 0", LED_dirty); end
  endtask

  task automatic test_bounce;
    int unsigned s0;
    int lat;
    s0 = n_strobe;
    for (int i = 0; i < 6; i++) begin
      btn_load = (i % 2 == 0);
      step(2);
    end
    n_tests++; if (n_strobe !== s0) begin n_fail++; $display("FAIL bounce_early_strobe: got %0d expected %0d", n_strobe, s0); end
    btn_load = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_main);
      if (load_strobe) begin lat = i; break; end
    end
    n_tests++;
    if (lat < int'(SYNC + DEB) || lat > int'(SYNC + DEB + 3)) begin
      n_fail++; $display("FAIL bounce_latency: got %0d expected %0d..%0d", lat, SYNC + DEB, SYNC + DEB + 3);
    end
    step(20);
    btn_load = 1'b0;
    step(15);
    n_tests++; if (n_strobe - s0 !== 1) begin n_fail++; $display("FAIL bounce_strobes: got %0d expected 1", n_strobe - s0); end
    n_tests++; if (A !== exp_A) begin n_fail++; $display("FAIL bounce_A: got %0d expected %0d", A, exp_A); end
  endtask

  task automatic test_switch_bounce;
    int unsigned s0;
    s0 = n_strobe;
    for (int i = 0; i < 40; i++) begin
      sw_A     = (i % 2 == 1) ? 4'd8 : 4'd7;
      btn_load = (i >= 5 && i < 25);
      step(1);
    end
    n_tests++; if (n_strobe - s0 !== 1) begin n_fail++; $display("FAIL swb_strobes: got %0d expected 1", n_strobe - s0); end
    n_tests++; if (A !== exp_A) begin n_fail++; $display("FAIL swb_A_held: got %0d expected %0d", A, exp_A); end
    sw_A = 4'd8;
    step(12);
    n_tests++; if (LED_dirty !== 1'b1) begin n_fail++; $display("FAIL swb_dirty: got %0b expected 1", LED_dirty); end
    press(15, 15);
    exp_A = 4'd8;
    n_tests++; if (A !== exp_A) begin n_fail++; $display("FAIL swb_A_new: got %0d expected %0d", A, exp_A); end
  endtask

  task automatic test_hold;
    int unsigned s0;
    s0 = n_strobe;
    btn_load = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 40) sw_A = 4'd9;
      step(1);
    end
    n_tests++; if (n_strobe - s0 !== 1) begin n_fail++; $display("FAIL hold_strobes: got %0d expected 1", n_strobe - s0); end
    n_tests++; if (LED_dirty !== 1'b1) begin n_fail++; $display("FAIL hold_dirty: got %0b expected 1", LED_dirty); end
    n_tests++; if (A !== exp_A) begin n_fail++; $display("FAIL hold_A_kept: got %0d expected %0d", A, exp_A); end
    btn_load = 1'b0;
    step(15);
    press(15, 15);
    exp_A = 4'd9;
    n_tests++; if (A !== exp_A) begin n_fail++; $display("FAIL hold_A_new: got %0d expected %0d", A, exp_A); end
    n_tests++; if (n_strobe - s0 !== 2) begin n_fail++; $display("FAIL hold_total_strobes: got %0d expected 2", n_strobe - s0); end
  endtask

  task automatic test_reset_mid_press;
    int unsigned s0;
    btn_load = 1'b1;
    step(15);
    reset_n = 1'b0;
    #1;
    n_tests++; if ({A, B, Sub} !== 9'd0) begin n_fail++; $display("FAIL rmp_outputs: got %0h expected 0", {A, B, Sub}); end
    n_tests++; if (load_strobe !== 1'b0) begin n_fail++; $display("FAIL rmp_strobe: got %0b expected 0", load_strobe); end
    exp_A = '0; exp_B = '0; exp_Sub = 1'b0;
    step(3);
    reset_n = 1'b1;
    s0 = n_strobe;
    step(40);
    n_tests++; if (n_strobe !== s0) begin n_fail++; $display("FAIL rmp_held_strobe: got %0d expected %0d", n_strobe - s0, 0); end
    n_tests++; if (A !== 4'd0) begin n_fail++; $display("FAIL rmp_held_A: got %0d expected 0", A); end
    btn_load = 1'b0;
    step(15);
    press(15, 15);
    exp_A = sw_A; exp_B = sw_B; exp_Sub = sw_Sub;
    n_tests++; if (n_strobe - s0 !== 1) begin n_fail++; $display("FAIL rmp_strobes: got %0d expected 1", n_strobe - s0); end
    n_tests++; if ({A, B, Sub} !== {exp_A, exp_B, exp_Sub}) begin n_fail++; $display("FAIL rmp_reload: got %0h expected %0h", {A, B, Sub}, {exp_A, exp_B, exp_Sub}); end
  endtask

  task automatic test_random;
    int unsigned s0;
    int unsigned do_press;
    logic        want_dirty;
    for (int it = 0; it < 10; it++) begin
      sw_A   = 4'($urandom_range(0, 15));
      sw_B   = 4'($urandom_range(0, 15));
      sw_Sub = 1'($urandom_range(0, 1));
      do_press = $urandom_range(0, 1);
      step(12);
      s0 = n_strobe;
      if (do_press != 0) begin
        press(int'($urandom_range(10, 25)), 12);
        exp_A = sw_A; exp_B = sw_B; exp_Sub = sw_Sub;
      end else begin
        step(10);
      end
      want_dirty = ({sw_A, sw_B, sw_Sub} != {exp_A, exp_B, exp_Sub});
      n_tests++; if (n_strobe - s0 !== do_press) begin n_fail++; $display("FAIL rand%0d_strobes: got %0d expected %0d", it, n_strobe - s0, do_press); end
      n_tests++; if ({A, B, Sub} !== {exp_A, exp_B, exp_Sub}) begin n_fail++; $display("FAIL rand%0d_ops: got %0h expected %0h", it, {A, B, Sub}, {exp_A, exp_B, exp_Sub}); end
      n_tests++; if (LED_dirty !== want_dirty) begin n_fail++; $display("FAIL rand%0d_dirty: got %0b expected %0b", it, LED_dirty, want_dirty); end
    end
  endtask

`endif

  initial begin
    test_reset;
`ifdef AUTO_LOAD_EN
    test_auto_load;
`else
    test_clean_load;
    test_bounce;
    test_switch_bounce;
    test_hold;
    test_reset_mid_press;
    test_random;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
